// File: rtl/gen_scheduler_pkg.sv
// rtl/gen_scheduler_pkg.sv - shared constants, state/owner enums and helpers for gen_scheduler
package gen_scheduler_pkg;

    localparam int BOARD_SIZE     = 480;
    localparam int LOG_BOARD_SIZE = $clog2(BOARD_SIZE);
    localparam int VTOTAL         = 524;
    localparam int WIN_CLOSE_V    = VTOTAL - 1;
    localparam int GEN_LAST_V     = 500;
    localparam int SPEED_WIDTH    = 4;
    localparam int HCOUNT_WIDTH   = 11;
    localparam int VCOUNT_WIDTH   = 10;
    localparam int ADDR_WIDTH     = 2 * LOG_BOARD_SIZE;

    typedef enum logic [1:0] {
        RENDER = 2'd0,
        ENGINE = 2'd1,
        EDITOR = 2'd2
    } mem_owner_t;

    typedef enum logic [1:0] {
        DISPLAY = 2'd0,
        IDLE    = 2'd1,
        EDIT    = 2'd2,
        UPDATE  = 2'd3
    } sched_state_t;

    function automatic mem_owner_t owner_of(input sched_state_t s);
        case (s)
            EDIT:    return EDITOR;
            UPDATE:  return ENGINE;
            default: return RENDER;
        endcase
    endfunction

endpackage

// File: rtl/gen_scheduler_if.sv
// rtl/gen_scheduler_if.sv - raster, control, editor and engine signals of gen_scheduler
interface gen_scheduler_if;
    import gen_scheduler_pkg::*;

    logic [HCOUNT_WIDTH-1:0]   hcount_in;
    logic [VCOUNT_WIDTH-1:0]   vcount_in;
    logic                      run_in;
    logic                      step_in;
    logic [SPEED_WIDTH-1:0]    speed_in;
    logic                      edit_req_in;
    logic [LOG_BOARD_SIZE-1:0] edit_x_in;
    logic [LOG_BOARD_SIZE-1:0] edit_y_in;
    logic                      edit_ack_out;
    logic                      edit_we_out;
    logic [ADDR_WIDTH-1:0]     edit_addr_out;
    logic                      gen_start_out;
    logic                      gen_done_in;
    logic [1:0]                mem_owner_out;
    logic [15:0]               gen_count_out;
    logic                      overrun_out;

    modport master (
        output hcount_in, vcount_in, run_in, step_in, speed_in,
        output edit_req_in, edit_x_in, edit_y_in, gen_done_in,
        input  edit_ack_out, edit_we_out, edit_addr_out, gen_start_out,
        input  mem_owner_out, gen_count_out, overrun_out
    );

    modport slave (
        input  hcount_in, vcount_in, run_in, step_in, speed_in,
        input  edit_req_in, edit_x_in, edit_y_in, gen_done_in,
        output edit_ack_out, edit_we_out, edit_addr_out, gen_start_out,
        output mem_owner_out, gen_count_out, overrun_out
    );

endinterface

// File: rtl/gen_scheduler_frame_divider.sv
// rtl/gen_scheduler_frame_divider.sv - frame pacing counter and single-step request
module gen_scheduler_frame_divider
    import gen_scheduler_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   window_open,
    input  logic                   run,
    input  logic                   step,
    input  logic [SPEED_WIDTH-1:0] speed,
    input  logic                   clear,
    output logic                   gen_due
);

    localparam logic [SPEED_WIDTH-1:0] CNT_MAX = '1;

    logic [SPEED_WIDTH-1:0] frame_cnt;
    logic                   armed;
    logic                   step_pending;

    // armed compares the count as it stood before this window's increment,
    // so speed+1 frames elapse between generations while free-running.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_cnt    <= '0;
            armed        <= 1'b0;
            step_pending <= 1'b0;
        end else begin
            if (clear) begin
                frame_cnt <= '0;
                armed     <= 1'b0;
            end else if (window_open) begin
                armed <= (frame_cnt >= speed);
                if (frame_cnt != CNT_MAX) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (step && !run) begin
                step_pending <= 1'b1;
            end else if (clear) begin
                step_pending <= 1'b0;
            end
        end
    end

    assign gen_due = (run && armed) || step_pending;

endmodule

// File: rtl/gen_scheduler.sv
// rtl/gen_scheduler.sv - board memory arbiter and generation scheduler
module gen_scheduler
    import gen_scheduler_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_n_in,
    gen_scheduler_if.slave bus
);

    sched_state_t          state_q;
    sched_state_t          state_d;
    mem_owner_t            owner_q;
    logic                  edit_ack_q;
    logic                  edit_we_q;
    logic [ADDR_WIDTH-1:0] edit_addr_q;
    logic                  gen_start_q;
    logic [15:0]           gen_count_q;
    logic                  overrun_q;
    logic                  late_q;
    logic                  gen_started_q;

    logic window_open;
    logic window_close;
    logic gen_due;
    logic gen_ok;
    logic done_ok;
    logic enter_update;

    assign window_open  = (bus.hcount_in == '0) && (bus.vcount_in == VCOUNT_WIDTH'(BOARD_SIZE));
    assign window_close = (bus.hcount_in == '0) && (bus.vcount_in == VCOUNT_WIDTH'(WIN_CLOSE_V));

    // A done pulse in the same cycle as gen_start cannot belong to this generation.
    assign done_ok = (state_q == UPDATE) && bus.gen_done_in && !gen_start_q;

    // gen_started_q limits service to one generation per window, so a step
    // arriving mid-update waits for the following window.
    assign gen_ok = gen_due && !gen_started_q &&
                    (bus.vcount_in <= VCOUNT_WIDTH'(GEN_LAST_V));

    assign enter_update = (state_q == IDLE) && (state_d == UPDATE);

    gen_scheduler_frame_divider u_frame_divider (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .window_open (window_open),
        .run         (bus.run_in),
        .step        (bus.step_in),
        .speed       (bus.speed_in),
        .clear       (enter_update),
        .gen_due     (gen_due)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            DISPLAY: begin
                if (window_open) state_d = IDLE;
            end
            IDLE: begin
                if (window_close)         state_d = DISPLAY;
                else if (bus.edit_req_in) state_d = EDIT;
                else if (gen_ok)          state_d = UPDATE;
            end
            EDIT: begin
                state_d = window_close ? DISPLAY : IDLE;
            end
            UPDATE: begin
                if (done_ok) state_d = (late_q || window_close) ? DISPLAY : IDLE;
            end
            default: state_d = DISPLAY;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= DISPLAY;
            owner_q       <= RENDER;
            edit_ack_q    <= 1'b0;
            edit_we_q     <= 1'b0;
            edit_addr_q   <= '0;
            gen_start_q   <= 1'b0;
            gen_count_q   <= '0;
            overrun_q     <= 1'b0;
            late_q        <= 1'b0;
            gen_started_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_of(state_d);
            edit_ack_q  <= (state_d == EDIT);
            edit_we_q   <= (state_d == EDIT);
            gen_start_q <= enter_update;
            if (state_d == EDIT) begin
                edit_addr_q <= {bus.edit_y_in, bus.edit_x_in};
            end
            if (done_ok) begin
                gen_count_q <= gen_count_q + 16'd1;
            end
            if ((state_q == UPDATE) && window_close && !done_ok) begin
                overrun_q <= 1'b1;
            end
            if (state_d != UPDATE) begin
                late_q <= 1'b0;
            end else if (window_close) begin
                late_q <= 1'b1;
            end
            if (window_open) begin
                gen_started_q <= 1'b0;
            end else if (enter_update) begin
                gen_started_q <= 1'b1;
            end
        end
    end

    assign bus.mem_owner_out = owner_q;
    assign bus.edit_ack_out  = edit_ack_q;
    assign bus.edit_we_out   = edit_we_q;
    assign bus.edit_addr_out = edit_addr_q;
    assign bus.gen_start_out = gen_start_q;
    assign bus.gen_count_out = gen_count_q;
    assign bus.overrun_out   = overrun_q;

endmodule
